// File: rtl/mult_div_unit.sv
// HI/LO multiply/divide unit for the E stage. Start pulses launch a fixed-latency
// operation; the result lands in HI/LO on the edge where busy drops.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | accepting start: mult/div launch, mthi/mtlo write HI/LO
// RUN   | operation in flight, busy=1, counter counts down to 1
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [CNT_W-1:0] counter;
  logic [1:0]       op_q;
  logic [31:0]      a_q;
  logic [31:0]      b_q;

  logic [63:0]      prod_s;
  logic [63:0]      prod_u;
  logic [31:0]      quot;
  logic [31:0]      rem;

  always_comb begin
    prod_s = 64'($signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q}));
    prod_u = {32'b0, a_q} * {32'b0, b_q};
    quot   = '0;
    rem    = '0;
    if (op_q[0]) begin
      quot = a_q / b_q;
      rem  = a_q % b_q;
    end else if (a_q == 32'h8000_0000 && b_q == 32'hFFFF_FFFF) begin
      // Only signed overflow case: quotient wraps back to the dividend.
      quot = 32'h8000_0000;
      rem  = '0;
    end else begin
      quot = $unsigned($signed(a_q) / $signed(b_q));
      rem  = $unsigned($signed(a_q) % $signed(b_q));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      busy    <= 1'b0;
      HI      <= '0;
      LO      <= '0;
      counter <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            case (op)
              3'd0, 3'd1, 3'd2, 3'd3: begin
                op_q    <= op[1:0];
                a_q     <= A;
                b_q     <= B;
                counter <= op[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                busy    <= 1'b1;
                state   <= RUN;
              end
              3'd4:    HI <= A;
              3'd5:    LO <= A;
              default: ;
            endcase
          end
        end
        RUN: begin
          if (counter == CNT_W'(1)) begin
            busy    <= 1'b0;
            counter <= '0;
            state   <= IDLE;
            if (!op_q[1]) begin
              {HI, LO} <= op_q[0] ? prod_u : prod_s;
            end else if (b_q != 32'd0) begin
              HI <= rem;
              LO <= quot;
            end
          end else begin
            counter <= counter - CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: an arithmetic reference model checked every
// cycle, plus literal expectations for each scenario.
module tb_mult_div_unit;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  int checks   = 0;
  int failures = 0;

  mult_div_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
    .busy(busy), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: result from plain arithmetic, completion tracked by edge number.
  function automatic logic [64:0] model_result(input logic [2:0] o, input logic [31:0] a,
                                              input logic [31:0] b);
    longint          p;
    longint unsigned pu;
    longint          q;
    longint          r;
    logic [31:0]     uq;
    logic [31:0]     ur;
    model_result = '0;
    case (o)
      3'd0: begin
        p = longint'($signed(a)) * longint'($signed(b));
        model_result = {1'b1, 64'(p)};
      end
      3'd1: begin
        pu = longint'(a) * longint'(b);
        model_result = {1'b1, 64'(pu)};
      end
      3'd2: if (b != 0) begin
        q = longint'(int'(a)) / longint'(int'(b));
        r = longint'(int'(a)) % longint'(int'(b));
        model_result = {1'b1, 32'(r), 32'(q)};
      end
      3'd3: if (b != 0) begin
        uq = a / b;
        ur = a % b;
        model_result = {1'b1, ur, uq};
      end
      default: ;
    endcase
  endfunction

  logic        model_valid = 1'b0;
  logic        m_busy = 1'b0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  logic [64:0] m_res = '0;
  int          m_done = 0;
  int          edge_cnt = 0;

  always @(posedge clk) begin
    edge_cnt++;
    if (reset) begin
      m_busy = 1'b0;
      m_hi = '0;
      m_lo = '0;
      model_valid = 1'b1;
    end else if (m_busy) begin
      if (edge_cnt == m_done) begin
        m_busy = 1'b0;
        if (m_res[64]) begin
          m_hi = m_res[63:32];
          m_lo = m_res[31:0];
        end
      end
    end else if (start) begin
      if (op <= 3'd3) begin
        m_res = model_result(op, A, B);
        m_busy = 1'b1;
        m_done = edge_cnt + ((op < 3'd2) ? MULT_N : DIV_N);
      end else if (op == 3'd4) begin
        m_hi = A;
      end else if (op == 3'd5) begin
        m_lo = A;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (model_valid) begin
        check("cyc_busy", {31'b0, busy}, {31'b0, m_busy});
        check("cyc_hi", HI, m_hi);
        check("cyc_lo", LO, m_lo);
      end
    end
  end

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1;
    op = o;
    A = a;
    B = b;
    @(negedge clk);
    start = 1'b0;
    op = 3'd7;
  endtask

  // Counts busy cycles starting at the current negedge; returns at the first idle negedge.
  task automatic wait_busy(output int n);
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (n >= 200) begin
      failures++;
      $display("FAIL busy_timeout: busy still high after %0d cycles", n);
    end
  endtask

  initial begin
    int n;
    reset = 1'b1;
    start = 1'b0;
    op = 3'd7;
    A = '0;
    B = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_hi", HI, 32'h0);
    check("rst_lo", LO, 32'h0);

    // Reset in the third busy cycle aborts the multiply.
    issue(3'd0, 32'd3, 32'd4);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_hi", HI, 32'h0);
    check("abort_lo", LO, 32'h0);
    repeat (8) @(negedge clk);
    check("abort_no_late_lo", LO, 32'h0);

    issue(3'd0, 32'hFFFF_FFFD, 32'd5);
    wait_busy(n);
    check("mult_cycles", 32'(n), 32'd5);
    check("mult_hi", HI, 32'hFFFF_FFFF);
    check("mult_lo", LO, 32'hFFFF_FFF1);

    issue(3'd1, 32'hFFFF_FFFF, 32'd2);
    wait_busy(n);
    check("multu_cycles", 32'(n), 32'd5);
    check("multu_hi", HI, 32'h0000_0001);
    check("multu_lo", LO, 32'hFFFF_FFFE);

    issue(3'd2, 32'hFFFF_FFF9, 32'd2);
    wait_busy(n);
    check("div_cycles", 32'(n), 32'd10);
    check("div_lo", LO, 32'hFFFF_FFFD);
    check("div_hi", HI, 32'hFFFF_FFFF);

    issue(3'd3, 32'd7, 32'd2);
    wait_busy(n);
    check("divu_lo", LO, 32'd3);
    check("divu_hi", HI, 32'd1);

    issue(3'd2, 32'd7, 32'hFFFF_FFFE);
    wait_busy(n);
    check("div_negdiv_lo", LO, 32'hFFFF_FFFD);
    check("div_negdiv_hi", HI, 32'd1);

    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_busy(n);
    check("div_ovf_lo", LO, 32'h8000_0000);
    check("div_ovf_hi", HI, 32'h0);

    issue(3'd4, 32'h1111_1111, 32'd0);
    check("mthi_busy", {31'b0, busy}, 32'd0);
    issue(3'd5, 32'h2222_2222, 32'd0);
    check("mtlo_busy", {31'b0, busy}, 32'd0);
    check("mthi_hi", HI, 32'h1111_1111);
    check("mtlo_lo", LO, 32'h2222_2222);

    issue(3'd6, 32'h3333_3333, 32'd1);
    check("noop_busy", {31'b0, busy}, 32'd0);
    check("noop_hi", HI, 32'h1111_1111);

    issue(3'd3, 32'd9, 32'd0);
    wait_busy(n);
    check("div0_cycles", 32'(n), 32'd10);
    check("div0_hi", HI, 32'h1111_1111);
    check("div0_lo", LO, 32'h2222_2222);

    // mthi pulsed mid-operation and operand changes must both be ignored.
    issue(3'd0, 32'd2, 32'd3);
    @(negedge clk);
    start = 1'b1;
    op = 3'd4;
    A = 32'hDEAD_BEEF;
    @(negedge clk);
    start = 1'b0;
    op = 3'd7;
    A = '0;
    B = '0;
    wait_busy(n);
    check("ign_cycles", 32'(n), 32'd3);
    check("ign_hi", HI, 32'h0);
    check("ign_lo", LO, 32'd6);

    // Back-to-back: divide launched in the first idle cycle after a multiply.
    issue(3'd1, 32'd5, 32'd7);
    wait_busy(n);
    check("b2b_mult_lo", LO, 32'd35);
    check("b2b_mult_hi", HI, 32'd0);
    start = 1'b1;
    op = 3'd2;
    A = 32'd100;
    B = 32'd7;
    @(negedge clk);
    start = 1'b0;
    op = 3'd7;
    check("b2b_busy_again", {31'b0, busy}, 32'd1);
    check("b2b_prior_lo", LO, 32'd35);
    wait_busy(n);
    check("b2b_div_cycles", 32'(n), 32'd10);
    check("b2b_div_lo", LO, 32'd14);
    check("b2b_div_hi", HI, 32'd2);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Multiply/divide responder in the E stage of the five-stage MIPS pipeline.
- Accepts one-cycle start pulses from the datapath for mult/multu/div/divu and mthi/mtlo writes.
- Holds the HI/LO architectural registers.
- Drives `busy` back to the hazard controller, which stalls any HI/LO-dependent instruction while an operation is in flight.

Parameters:
- MULT_CYCLES, 5, number of busy cycles for mult/multu (must be ≥1).
- DIV_CYCLES, 10, number of busy cycles for div/divu (must be ≥1).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request; qualifies op/A/B.
- op  input  3  0=mult, 1=multu, 2=div, 3=divu, 4=mthi, 5=mtlo, 6/7=no-op.
- A  input  32  rs operand (E-stage forwarded value).
- B  input  32  rt operand (E-stage forwarded value).
- busy  output  1  operation in flight.
- HI  output  32  HI register, registered.
- LO  output  32  LO register, registered.

Behaviour:
- Interface: one clock, `clk`; reset is synchronous and active-high, named `reset`.
- Reset: busy=0, HI=0, LO=0, counter=0, state IDLE. Reset mid-operation aborts it; HI/LO are zeroed, and the pending result is discarded.
- States: IDLE, RUN.
- IDLE, start=1, op∈{0..3}:
  - Latch A, B and op into internal operand registers.
  - Load counter with MULT_CYCLES (op 0/1) or DIV_CYCLES (op 2/3).
  - Go to RUN.
  - busy=1 from the next cycle.
- IDLE, start=1, op=4: HI<=A at that edge; LO unchanged; busy stays 0.
- IDLE, start=1, op=5: LO<=A at that edge; HI unchanged; busy stays 0.
- IDLE, start=1, op 6/7: no state change.
- RUN: counter decrements each cycle. When counter==1 at an edge:
  - Write HI/LO from the latched operands.
  - Set busy<=0 and return to IDLE.
- Timing example for start at edge T0: busy=1 during the N cycles after T0. New HI/LO are visible in the same cycle busy first reads 0 (edge T0+N).
- Results are computed from the latched operands only; A/B changes during RUN have no effect.
- mult: {HI,LO} = signed(A) × signed(B), full 64-bit product.
- multu: {HI,LO} = unsigned(A) × unsigned(B).
- div:
  - LO = signed quotient, truncated toward zero.
  - HI = signed remainder; its sign follows the dividend.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- divu: LO = unsigned quotient; HI = unsigned remainder.
- Divide by zero (B==0, op 2/3): the unit still runs DIV_CYCLES busy cycles; HI/LO are left unchanged at completion.
- start while busy=1 (any op, including mthi/mtlo): ignored; the in-flight operation and HI/LO are unaffected. The hazard controller guarantees this does not occur; the block must still be robust to it.
- Stall combination: the hazard controller stalls on (start & op∈{0..3}) | busy. The block itself asserts busy only from the cycle after start.
- HI/LO are never written except at completion, by mthi/mtlo, or by reset.
- Read latency: HI/LO are readable (mfhi/mflo) combinationally from the registers in any cycle busy=0.

Test Plan:
- Reset held 2 cycles, then released -> busy=0, HI=0x00000000, LO=0x00000000. Start mult 3×4, then assert reset in the 3rd busy cycle -> busy=0 next cycle; HI=LO=0; no late write afterwards.
- mult with A=0xFFFFFFFD (−3), B=5 -> busy=1 for exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFF1. Repeat as multu with A=0xFFFFFFFF, B=2 -> HI=0x00000001, LO=0xFFFFFFFE.
- div with A=0xFFFFFFF9 (−7), B=2 -> busy for 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF. Repeat as divu with A=7, B=2 -> LO=3, HI=1.
- Preload HI=0x11111111, LO=0x22222222 via mthi/mtlo (busy never rises). Then divu with B=0 -> 10 busy cycles; HI/LO remain 0x11111111/0x22222222.
- Start mult with A=2, B=3. On the 2nd busy cycle pulse start with op=4 (mthi), A=0xDEADBEEF, and change A/B to 0. -> Ignored; at completion HI=0, LO=6.
- Back-to-back: start div on the same edge busy falls from a prior mult -> new op is accepted, and busy re-asserts the next cycle. The prior mult result is visible for one cycle, then overwritten at div completion.
